// File: rtl/cache_sa_wb.sv
// -----------------------------------------------------------------------------
// cache_sa_wb
//
// Set-associative, write-back, write-allocate data cache sitting between a
// single-word CPU port and a block-wide main-memory port.
//
//   * WAYS-way associativity with true-LRU replacement.
//     Each line keeps an age; the ages of a set are a permutation of
//     0..WAYS-1, and age 0 is the most recently used line.
//   * CPU side uses a request/done handshake.
//     The CPU holds cpu_req until it sees the one-cycle cpu_done pulse.
//   * Memory side uses a req/ack handshake.
//     mem_req, mem_we, mem_addr and mem_wdata stay constant until mem_ack.
//   * hit_cnt and miss_cnt are saturating 16-bit event counters.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request (byte address, bits [1:0] ignored)
//   cpu_done/hit/rdata        one-cycle completion, hit flag, read data
//   mem_req/we/addr/wdata     block write-back (we=1) or fetch (we=0)
//   mem_rdata, mem_ack        fetched block, one-cycle acknowledge
//   hit_cnt, miss_cnt         saturating statistics counters
// -----------------------------------------------------------------------------
module cache_sa_wb #(
  parameter int ADDR_W = 10,
  parameter int WAYS   = 2,
  parameter int SETS   = 2,
  parameter int WORDS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_done,
  output logic                cpu_hit,
  output logic [31:0]         cpu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [32*WORDS-1:0] mem_wdata,
  input  logic [32*WORDS-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);

  localparam int OFF_W = $clog2(WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  // Way and word selectors keep at least one bit, so that the direct-mapped
  // and single-word configurations still have legal vectors.
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BLK_W = 32 * WORDS;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] REFILL    = 3'd4;
  localparam logic [2:0] RESPOND   = 3'd5;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  logic [2:0]        state_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [WAY_W-1:0]  victim_reg;

  // Line status. This is flop-based because reset must invalidate every line
  // and restore the age permutation.
  logic [WAYS-1:0]   valid_reg [SETS];
  logic [WAYS-1:0]   dirty_reg [SETS];
  logic [WAY_W-1:0]  age_reg   [SETS][WAYS];

  // Line payload. This has no reset, because contents of invalid lines are
  // never observed.
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [BLK_W-1:0]  data_mem  [SETS][WAYS];

  // ---------------------------------------------------------------------------
  // Address fields of the captured request
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]  tag_f;
  logic [IDX_W-1:0]  set_idx;
  logic [WRD_W-1:0]  word_idx;
  logic [WRD_W+4:0]  bit_off;
  logic [ADDR_W-1:0] blk_addr;
  logic              unused_addr_bits;

  assign tag_f    = addr_reg[ADDR_W-1:IDX_W+OFF_W];
  assign set_idx  = addr_reg[IDX_W+OFF_W-1:OFF_W];
  assign bit_off  = {word_idx, 5'd0};
  assign blk_addr = {tag_f, set_idx, {OFF_W{1'b0}}};
  // The byte offset within a word has no meaning for a word-wide port.
  assign unused_addr_bits = ^addr_reg[1:0];

  generate
    if (WORDS > 1) begin : g_word_sel
      assign word_idx = addr_reg[OFF_W-1:2];
    end else begin : g_word_single
      assign word_idx = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Tag compare and LRU age update for every way of the addressed set
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0]             hit_vec;
  logic                        hit_any;
  logic [WAY_W-1:0]            hit_way;
  logic [WAY_W-1:0]            lru_way;
  logic [WAY_W-1:0]            lru_old_age;
  logic [WAYS-1:0][WAY_W-1:0]  age_next;

  // The line being touched is the hit way during LOOKUP, and the victim way
  // while its refill completes.
  assign lru_way     = (state_reg == REFILL) ? victim_reg : hit_way;
  assign lru_old_age = age_reg[set_idx][lru_way];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_reg[set_idx][gi] &&
                           (tag_mem[set_idx][gi] == tag_f);

      // The touched way becomes youngest. Only ways younger than its old age
      // move back one step, which keeps the ages a permutation.
      assign age_next[gi] =
        (WAY_W'(gi) == lru_way)              ? '0 :
        (age_reg[set_idx][gi] < lru_old_age) ? age_reg[set_idx][gi] + WAY_W'(1) :
                                               age_reg[set_idx][gi];
    end
  endgenerate

  assign hit_any = |hit_vec;

  // Tags within a set are unique, so at most one bit of hit_vec is set.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // ---------------------------------------------------------------------------
  // Victim choice
  //   1. Use the lowest-numbered invalid way.
  //   2. If every way is valid, use the oldest way (age WAYS-1).
  // ---------------------------------------------------------------------------
  logic [WAY_W-1:0] victim_sel;
  logic             victim_found;

  always_comb begin
    victim_sel   = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_reg[set_idx][w]) begin
        victim_sel   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_reg[set_idx][w] == WAY_W'(WAYS - 1)) victim_sel = WAY_W'(w);
      end
    end
  end

  logic [BLK_W-1:0] hit_blk;
  logic [31:0]      hit_word;
  logic [BLK_W-1:0] victim_blk;
  logic [TAG_W-1:0] victim_tag;
  logic             victim_dirty;

  assign hit_blk      = data_mem[set_idx][hit_way];
  assign hit_word     = hit_blk[bit_off +: 32];
  assign victim_blk   = data_mem[set_idx][victim_sel];
  assign victim_tag   = tag_mem[set_idx][victim_sel];
  assign victim_dirty = valid_reg[set_idx][victim_sel] &&
                        dirty_reg[set_idx][victim_sel];

  // ---------------------------------------------------------------------------
  // Write enables and refill merge
  // ---------------------------------------------------------------------------
  logic             fill_en;
  logic             hit_wr_en;
  logic             lru_en;
  logic [BLK_W-1:0] fill_block;

  assign fill_en   = (state_reg == REFILL) && mem_req && mem_ack;
  assign hit_wr_en = (state_reg == LOOKUP) && hit_any && we_reg;
  assign lru_en    = ((state_reg == LOOKUP) && hit_any) || fill_en;

  // A write miss merges the CPU word into the incoming block, so that the
  // fill and the store land on the same edge.
  always_comb begin
    fill_block = mem_rdata;
    if (we_reg) fill_block[bit_off +: 32] = wdata_reg;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[set_idx][victim_reg] <= fill_block;
      tag_mem[set_idx][victim_reg]  <= tag_f;
    end else if (hit_wr_en) begin
      data_mem[set_idx][hit_way][bit_off +: 32] <= wdata_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, line status and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      victim_reg <= '0;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_reg[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      // cpu_done is a single-cycle pulse raised only on entry to RESPOND.
      cpu_done <= 1'b0;

      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          age_reg[set_idx][w] <= age_next[w];
        end
      end

      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            we_reg    <= cpu_we;
            addr_reg  <= cpu_addr;
            wdata_reg <= cpu_wdata;
            state_reg <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit_any) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (we_reg) dirty_reg[set_idx][hit_way] <= 1'b1;
            else        cpu_rdata <= hit_word;
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            state_reg <= RESPOND;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            victim_reg <= victim_sel;
            mem_req    <= 1'b1;
            // The victim block is latched here even on a clean miss, so that
            // mem_wdata never changes while mem_req is high.
            mem_wdata  <= victim_blk;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {victim_tag, set_idx, {OFF_W{1'b0}}};
              state_reg <= WRITEBACK;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= blk_addr;
              state_reg <= REFILL;
            end
          end
        end

        WRITEBACK: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= GAP;
          end
        end

        // This state forces one idle cycle between the write-back and the
        // refill, so that memory sees two distinct requests.
        GAP: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= blk_addr;
          state_reg <= REFILL;
        end

        REFILL: begin
          if (mem_ack) begin
            mem_req                        <= 1'b0;
            valid_reg[set_idx][victim_reg] <= 1'b1;
            dirty_reg[set_idx][victim_reg] <= we_reg;
            if (!we_reg) cpu_rdata <= mem_rdata[bit_off +: 32];
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b0;
            state_reg <= RESPOND;
          end
        end

        RESPOND: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa_wb.sv
// -----------------------------------------------------------------------------
// tb_cache_sa_wb
//
// Self-checking bench for cache_sa_wb in its default configuration:
//   2 ways, 2 sets, 4 words per block, 10-bit address.
//
// Checking is split between three pieces:
//   * Scoreboard. A CPU-visible reference memory predicts every completion;
//     expectations are queued when a request is issued and popped when
//     cpu_done fires.
//   * Memory responder. A behavioural main memory with programmable ack delay.
//     It logs each block transaction and watches request stability.
//   * Scenario tasks. Each task compares latencies, the memory-transaction log
//     and the counters inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_sa_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_done;
  logic         cpu_hit;
  logic [31:0]  cpu_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  always #5 clk = ~clk;

  cache_sa_wb #(.ADDR_W(10), .WAYS(2), .SETS(2), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Main memory contents (mem_model) and the CPU's coherent view (ref_mem).
  logic [31:0] mem_model [256];
  logic [31:0] ref_mem   [256];

  typedef struct {
    logic       is_read;
    logic       hit;
    logic [31:0] rdata;
    logic [9:0] addr;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] last_rdata = '0;

  typedef struct {
    logic         we;
    logic [9:0]   addr;
    logic [127:0] wdata;
    int           start;
    int           ack;
    logic         gap_low;
  } mlog_t;
  mlog_t mlog[$];

  int           ack_delay = 0;
  int           wait_cnt = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  logic [9:0]   req_addr0 = '0;
  logic [127:0] req_wdata0 = '0;
  logic         req_we0 = 1'b0;
  logic         mem_unstable = 1'b0;
  logic         prev_low = 1'b0;

  // ---------------------------------------------------------------------------
  // Memory responder. It acks a request ack_delay cycles after first seeing it.
  // prev_low records whether mem_req was low in the cycle after an ack.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      prev_low = !mem_req;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        req_addr0  = mem_addr;
        req_wdata0 = mem_wdata;
        req_we0    = mem_we;
        start_cyc  = cyc;
      end else if (mem_addr !== req_addr0 || mem_wdata !== req_wdata0 ||
                   mem_we !== req_we0) begin
        mem_unstable = 1'b1;
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        for (int w = 0; w < 4; w++) begin
          if (mem_we) mem_model[{mem_addr[9:4], 2'(w)}] = mem_wdata[w*32 +: 32];
          else        mem_rdata[w*32 +: 32] = mem_model[{mem_addr[9:4], 2'(w)}];
        end
        mlog.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata,
                         start: start_cyc, ack: cyc, gap_low: prev_low});
        prev_low = 1'b0;
      end
      wait_cnt = wait_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: each cpu_done pops one expectation.
  // A write expects cpu_rdata to still hold the last read value.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && cpu_done) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL sb_unexpected_done: got cpu_done=1 required no completion");
      end else begin
        mon_e  = exp_q.pop_front();
        checks = checks + 2;
        if (cpu_hit !== mon_e.hit) begin
          errors = errors + 1;
          $display("FAIL sb_hit addr=%h: got %0b required %0b", mon_e.addr, cpu_hit, mon_e.hit);
        end
        if (cpu_rdata !== mon_e.rdata) begin
          errors = errors + 1;
          $display("FAIL sb_rdata addr=%h read=%0b: got %h required %h",
                   mon_e.addr, mon_e.is_read, cpu_rdata, mon_e.rdata);
        end
        $display("txn addr=%h %s hit=%0b rdata=%h", mon_e.addr,
                 mon_e.is_read ? "RD" : "WR", cpu_hit, cpu_rdata);
      end
    end
  end

  // One CPU access: queue the expected result, then run the handshake.
  // lat counts cycles from driving cpu_req to seeing cpu_done.
  task automatic access(input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic exp_hit,
                        output int lat);
    exp_t e;
    e.is_read = !we;
    e.hit     = exp_hit;
    e.addr    = addr;
    if (we) begin
      ref_mem[addr[9:2]] = wdata;
      e.rdata = last_rdata;
    end else begin
      e.rdata    = ref_mem[addr[9:2]];
      last_rdata = e.rdata;
    end
    exp_q.push_back(e);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat = lat + 1;
    end while (!cpu_done && lat < 300);
    if (!cpu_done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL access_timeout addr=%h: no cpu_done after %0d cycles, required completion", addr, lat);
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    mlog.delete();
    exp_q.delete();
    mem_unstable = 1'b0;
    // Dirty data not yet written back is lost, so the CPU view falls back to
    // main memory.
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_model[i];
    last_rdata = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks = checks + 4;
    if (cpu_done !== 1'b0 || cpu_hit !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_cpu_flags: got done=%0b hit=%0b required 0 0", cpu_done, cpu_hit);
    end
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h000) begin
      errors = errors + 1;
      $display("FAIL reset_mem_port: got req=%0b we=%0b addr=%h required 0 0 000", mem_req, mem_we, mem_addr);
    end
    if (cpu_rdata !== 32'h0 || mem_wdata !== 128'h0) begin
      errors = errors + 1;
      $display("FAIL reset_data: got rdata=%h wdata=%h required 0", cpu_rdata, mem_wdata);
    end
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors = errors + 1;
      $display("FAIL reset_counters: got hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_cold_read();
    int lat;
    access(1'b0, 10'h000, 32'h0, 1'b0, lat);
    checks = checks + 2;
    if (mlog.size() != 1 || mlog[0].we !== 1'b0 || mlog[0].addr !== 10'h000) begin
      errors = errors + 1;
      $display("FAIL cold_refill: got %0d txns first we=%0b addr=%h required 1 fetch at 000",
               mlog.size(), mlog[0].we, mlog[0].addr);
    end
    if (lat != 3) begin
      errors = errors + 1;
      $display("FAIL cold_latency: got %0d required 3", lat);
    end
    access(1'b0, 10'h008, 32'h0, 1'b1, lat);
    checks = checks + 2;
    if (lat != 2) begin
      errors = errors + 1;
      $display("FAIL hit_latency: got %0d required 2", lat);
    end
    if (mlog.size() != 1) begin
      errors = errors + 1;
      $display("FAIL hit_no_mem: got %0d mem txns required 1", mlog.size());
    end
  endtask

  task automatic test_dirty_eviction();
    int lat;
    int n;
    access(1'b1, 10'h004, 32'hDEADBEEF, 1'b1, lat);
    access(1'b0, 10'h020, 32'h0, 1'b0, lat);
    n = mlog.size();
    access(1'b0, 10'h040, 32'h0, 1'b0, lat);
    checks = checks + 5;
    if (mlog.size() != n + 2) begin
      errors = errors + 1;
      $display("FAIL evict_txn_count: got %0d required %0d", mlog.size() - n, 2);
    end else begin
      if (mlog[n].we !== 1'b1 || mlog[n].addr !== 10'h000) begin
        errors = errors + 1;
        $display("FAIL evict_wb_addr: got we=%0b addr=%h required 1 000", mlog[n].we, mlog[n].addr);
      end
      if (mlog[n].wdata[63:32] !== 32'hDEADBEEF) begin
        errors = errors + 1;
        $display("FAIL evict_wb_data: got %h required deadbeef", mlog[n].wdata[63:32]);
      end
      if (mlog[n+1].we !== 1'b0 || mlog[n+1].addr !== 10'h040 || mlog[n+1].gap_low !== 1'b1 ||
          mlog[n+1].start - mlog[n].ack != 2) begin
        errors = errors + 1;
        $display("FAIL evict_gap_refill: got we=%0b addr=%h gap_low=%0b spacing=%0d required 0 040 1 2",
                 mlog[n+1].we, mlog[n+1].addr, mlog[n+1].gap_low, mlog[n+1].start - mlog[n].ack);
      end
    end
    if (lat != 5) begin
      errors = errors + 1;
      $display("FAIL evict_latency: got %0d required 5", lat);
    end
    // The written-back word must come back from main memory.
    access(1'b0, 10'h004, 32'h0, 1'b0, lat);
  endtask

  task automatic test_lru();
    int lat;
    int n;
    do_reset();
    access(1'b0, 10'h000, 32'h0, 1'b0, lat);
    access(1'b0, 10'h020, 32'h0, 1'b0, lat);
    access(1'b0, 10'h000, 32'h0, 1'b1, lat);
    n = mlog.size();
    access(1'b0, 10'h040, 32'h0, 1'b0, lat);
    checks = checks + 1;
    if (mlog.size() != n + 1 || mlog[n].we !== 1'b0 || mlog[n].addr !== 10'h040) begin
      errors = errors + 1;
      $display("FAIL lru_clean_victim: got %0d txns we=%0b addr=%h required 1 fetch at 040",
               mlog.size() - n, mlog[n].we, mlog[n].addr);
    end
    access(1'b0, 10'h000, 32'h0, 1'b1, lat);
    access(1'b0, 10'h020, 32'h0, 1'b0, lat);
  endtask

  task automatic test_slow_memory();
    int lat;
    int n;
    do_reset();
    ack_delay = 5;
    access(1'b0, 10'h0A0, 32'h0, 1'b0, lat);
    checks = checks + 1;
    if (lat != 8) begin
      errors = errors + 1;
      $display("FAIL slow_clean_latency: got %0d required 8", lat);
    end
    access(1'b1, 10'h0A4, 32'h12345678, 1'b1, lat);
    access(1'b0, 10'h0C0, 32'h0, 1'b0, lat);
    n = mlog.size();
    access(1'b0, 10'h0E0, 32'h0, 1'b0, lat);
    checks = checks + 4;
    if (lat != 15) begin
      errors = errors + 1;
      $display("FAIL slow_dirty_latency: got %0d required 15", lat);
    end
    if (mlog.size() != n + 2 || mlog[n].we !== 1'b1 || mlog[n].addr !== 10'h0A0 ||
        mlog[n].wdata[63:32] !== 32'h12345678) begin
      errors = errors + 1;
      $display("FAIL slow_wb: got we=%0b addr=%h word1=%h required 1 0a0 12345678",
               mlog[n].we, mlog[n].addr, mlog[n].wdata[63:32]);
    end
    if (mlog[n+1].ack - mlog[n+1].start != 5) begin
      errors = errors + 1;
      $display("FAIL slow_ack_wait: got %0d required 5", mlog[n+1].ack - mlog[n+1].start);
    end
    if (mem_unstable !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL slow_stable: got unstable=%0b required 0", mem_unstable);
    end
    ack_delay = 0;
  endtask

  task automatic test_set_isolation();
    int lat;
    do_reset();
    access(1'b0, 10'h000, 32'h0, 1'b0, lat);
    access(1'b0, 10'h010, 32'h0, 1'b0, lat);
    access(1'b0, 10'h000, 32'h0, 1'b1, lat);
    checks = checks + 2;
    if (hit_cnt !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL iso_hit_cnt: got %0d required 1", hit_cnt);
    end
    if (miss_cnt !== 16'd2) begin
      errors = errors + 1;
      $display("FAIL iso_miss_cnt: got %0d required 2", miss_cnt);
    end
    // A write hit leaves cpu_rdata unchanged, and set 1 still holds its line.
    access(1'b1, 10'h018, 32'hCAFEF00D, 1'b1, lat);
    access(1'b0, 10'h018, 32'h0, 1'b1, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 10'(i * 4), 32'h0, 1'b1, lat);
      checks = checks + 1;
      if (lat != 2) begin
        errors = errors + 1;
        $display("FAIL b2b_latency word=%0d: got %0d required 2", i, lat);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    int n;
    int t;
    do_reset();
    access(1'b0, 10'h000, 32'h0, 1'b0, lat);
    ack_delay = 100000;
    n = mlog.size();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'h040;
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t = t + 1;
    end
    checks = checks + 1;
    if (!mem_req) begin
      errors = errors + 1;
      $display("FAIL midrst_req_seen: got mem_req=0 required 1");
    end
    rst_n = 1'b0;
    #1;
    checks = checks + 2;
    if (mem_req !== 1'b0 || cpu_done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL midrst_drop: got mem_req=%0b cpu_done=%0b required 0 0", mem_req, cpu_done);
    end
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors = errors + 1;
      $display("FAIL midrst_counters: got hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
    cpu_req = 1'b0;
    do_reset();
    access(1'b0, 10'h000, 32'h0, 1'b0, lat);
    checks = checks + 1;
    if (mlog.size() != 1 || mlog[0].we !== 1'b0 || mlog[0].addr !== 10'h000 || n != 1) begin
      errors = errors + 1;
      $display("FAIL midrst_refetch: got %0d txns we=%0b addr=%h required 1 fetch at 000",
               mlog.size(), mlog[0].we, mlog[0].addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = (i < 4) ? 32'(i) * 32'h11 : (32'hC000_0000 | 32'(i));
    end
    test_reset();
    test_cold_read();
    test_dirty_eviction();
    test_lru();
    test_slow_memory();
    test_set_isolation();
    test_back_to_back();
    test_reset_mid_refill();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: got %0d pending completions required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_sa_wb.md
# cache_sa_wb

Parametrised set-associative, write-back, write-allocate data cache between the processor memory port and main memory. It replaces the fixed 2-way/2-set combinational cache model with a clocked FSM, a request/done handshake on the CPU side, and a req/ack handshake on the memory side. It also adds true-LRU replacement for any power-of-two way count and saturating hit/miss counters.

## Interface
- ADDR_W, 10, byte address width
- WAYS, 2, associativity; power of two, 1..8
- SETS, 2, number of sets; power of two, ≥2
- WORDS, 4, 32-bit words per block; power of two, ≥1
- Derived widths:
  - OFF_W = log2(WORDS)+2
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W−IDX_W−OFF_W, must be ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request; held by the CPU until cpu_done
- cpu_we  in  1  0 = read, 1 = write
- cpu_addr  in  ADDR_W  byte address; bits [1:0] are ignored
- cpu_wdata  in  32  write word
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  valid with cpu_done: 1 = hit, 0 = miss
- cpu_rdata  out  32  read word; valid with cpu_done on reads
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = block write-back, 0 = block fetch
- mem_addr  out  ADDR_W  block-aligned address; offset bits are 0
- mem_wdata  out  32*WORDS  victim block; word 0 is in bits [31:0]
- mem_rdata  in  32*WORDS  fetched block; sampled on mem_ack
- mem_ack  in  1  one-cycle acknowledge; ignored while mem_req=0
- hit_cnt  out  16  saturating hit count
- miss_cnt  out  16  saturating miss count

## Operation
- Address fields:
  - tag = addr[ADDR_W−1 : IDX_W+OFF_W]
  - index = addr[IDX_W+OFF_W−1 : OFF_W]
  - word = addr[OFF_W−1 : 2]
- Each line holds valid, dirty, tag, block data and a log2(WAYS)-bit age.
- FSM states: IDLE, LOOKUP, WRITEBACK, GAP, REFILL, RESPOND.
- IDLE: when cpu_req=1, capture we/addr/wdata and go to LOOKUP. Inputs are not re-sampled until the next IDLE.
- LOOKUP: compare the tag against every valid way in the set.
  - Hit: perform the access. A read loads cpu_rdata; a write updates the word and sets dirty. Increment hit_cnt, then go to RESPOND with cpu_hit=1.
  - Miss: increment miss_cnt and select the victim. The victim is the lowest-index invalid way; if all ways are valid, it is the way with age WAYS−1.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK: drive mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data. On mem_ack, go to GAP.
- GAP: mem_req=0 for exactly one cycle, then go to REFILL.
- REFILL: drive mem_req=1, mem_we=0, mem_addr={tag, index, 0}. On mem_ack:
  - install mem_rdata, tag, valid=1, dirty=0;
  - apply the pending op in the same edge: a write merges cpu_wdata and sets dirty=1; a read loads cpu_rdata from mem_rdata;
  - go to RESPOND with cpu_hit=0.
- RESPOND: cpu_done=1 for this cycle only, then go to IDLE. The CPU drops cpu_req on seeing cpu_done.
- LRU update on every hit or fill of way w with old age a:
  - w's age becomes 0;
  - every way in the set with age < a increments.
- Ages in a set always form a permutation of 0..WAYS−1.
- WAYS=1 makes the cache direct-mapped; the age logic is degenerate.
- cpu_rdata holds its value until the next read completes; writes leave it unchanged.
- Counters stick at 0xFFFF.
- mem_wdata and mem_addr are held constant for the whole time mem_req is high.

## Timing
- All outputs are registered, decoded from the state and datapath registers.
- Reset values:
  - all outputs are 0, state is IDLE;
  - every line has valid=0 and dirty=0;
  - way w has age w;
  - data and tag contents are don't-care.
- Hit: cpu_req sampled at edge E0, LOOKUP at E0, cpu_done high from E1 to E2. Two-cycle latency.
- Clean miss: mem_req rises at E1. For an ack sampled at edge Ek, cpu_done is high from Ek to Ek+1.
- Dirty miss: write-back ack sampled at Ej, mem_req low from Ej to Ej+1, refill mem_req high from Ej+1.
- mem_ack may arrive in the first cycle of mem_req; it has no maximum wait.
- Minimum gap between cpu_done pulses is 2 cycles (RESPOND → IDLE → LOOKUP).
- Reset asserted mid-operation: mem_req and cpu_done drop immediately (asynchronous), all lines become invalid, and the pending request is discarded with no write-back.

## Test plan
Defaults apply: tag=addr[9:5], index=addr[4], word=addr[3:2].

- **Cold read:** after reset, read 0x000 with mem_rdata={0x33,0x22,0x11,0x00} (word3..word0) → REFILL mem_addr=0x000, mem_we=0, cpu_done with cpu_hit=0, cpu_rdata=0x00. Then read 0x008 → cpu_hit=1, cpu_rdata=0x22, no mem_req, done 2 cycles after request.
- **Dirty eviction:** write 0x004 with 0xDEADBEEF (hit), fill 0x020, then read 0x040 → WRITEBACK mem_addr=0x000, mem_we=1, mem_wdata[63:32]=0xDEADBEEF; one-cycle mem_req gap; then REFILL mem_addr=0x040.
- **LRU order:** fill 0x000 and 0x020, read 0x000 (hit), then read 0x040 → victim is 0x020 (clean), no WRITEBACK. Then read 0x000 → cpu_hit=1.
- **Slow memory:** mem_ack delayed 5 cycles → mem_req, mem_addr and mem_wdata stable throughout, cpu_done stays 0 until 1 cycle after the ack.
- **Set isolation and counters:** a miss to 0x010 leaves the set-0 lines intact. After the sequence 0x000 miss, 0x010 miss, 0x000 hit → hit_cnt=1, miss_cnt=2.
- **Reset mid-refill:** pull rst_n low while mem_req=1 → mem_req=0 immediately, counters 0. After release, a read of 0x000 misses again.
